md_frame_assembler: RTL

Byte-serial market-data deframer that sits directly upstream of the trade-decision stage. It hunts for a sync byte, collects 8 payload bytes LSB-first, and checks an XOR checksum. Good frames are presented as one 64-bit data frame on a valid/ready output. Bad, late or unbuffered frames are dropped and counted.

---
 rtl/md_frame_assembler.sv | 103 ++++++++++
 1 files changed

// File: rtl/md_frame_assembler.sv
// Byte-serial deframer: sync hunt, 8 LSB-first payload bytes, XOR checksum, one-entry 64-bit output buffer.
// Frame result (load or error pulse) appears one cycle after the checksum byte; input is never backpressured.
module md_frame_assembler #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 16,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic [63:0]      frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             err_checksum,
  output logic             err_timeout,
  output logic             err_overflow,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  csum;
  logic [63:0] shreg;
  logic [GAP_W-1:0] gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      idx          <= 3'd0;
      csum         <= 8'd0;
      shreg        <= 64'd0;
      gap          <= '0;
      frame_data   <= 64'd0;
      frame_valid  <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      good_count   <= '0;
      drop_count   <= '0;
    end else begin
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      // A load below on the same edge overrides this pop.
      if (frame_valid && frame_ready) frame_valid <= 1'b0;

      case (state)
        HUNT: begin
          gap <= '0;
          if (in_valid && in_byte == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx   <= 3'd0;
            csum  <= 8'd0;
          end
        end
        PAYLOAD, CHECK: begin
          if (in_valid) begin
            gap <= '0;
            if (state == PAYLOAD) begin
              shreg[{idx, 3'b000} +: 8] <= in_byte;
              csum <= csum ^ in_byte;
              idx  <= idx + 3'd1;
              if (idx == 3'd7) state <= CHECK;
            end else begin
              state <= HUNT;
              if (in_byte == csum) begin
                if (!frame_valid || frame_ready) begin
                  frame_data  <= shreg;
                  frame_valid <= 1'b1;
                  if (good_count != CNT_MAX) good_count <= good_count + 1'b1;
                end else begin
                  err_overflow <= 1'b1;
                  if (drop_count != CNT_MAX) drop_count <= drop_count + 1'b1;
                end
              end else begin
                err_checksum <= 1'b1;
                if (drop_count != CNT_MAX) drop_count <= drop_count + 1'b1;
              end
            end
          end else if (gap == GAP_LAST) begin
            // This idle cycle would bring the gap count to TIMEOUT: abandon the frame.
            err_timeout <= 1'b1;
            if (drop_count != CNT_MAX) drop_count <= drop_count + 1'b1;
            state <= HUNT;
            gap   <= '0;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
